// File: rtl/arcade_input_mapper_if.sv
// Keymap configuration bus for arcade_input_mapper: write strobe, entry index, scan code.
interface arcade_input_mapper_if #(
    parameter int N = 16
) ();
    localparam int IW = $clog2(N);

    logic          cfg_wr;
    logic [IW-1:0] cfg_idx;
    logic [8:0]    cfg_code;

    modport master (output cfg_wr, cfg_idx, cfg_code);
    modport slave  (input  cfg_wr, cfg_idx, cfg_code);
endinterface

// File: rtl/arcade_input_mapper.sv
// PS/2 keymap search + joystick merge + SOCD cleaning for arcade cores.
// Optional autofire on button bit 4 when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS       = 2,
    parameter int INPUTS_PER_PLAYER = 8
) (
    input  logic                                     clk_sys,
    input  logic                                     reset_n,
    input  logic [10:0]                              ps2_key,
    input  logic [NUM_PLAYERS*INPUTS_PER_PLAYER-1:0] joy_in,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic [NUM_PLAYERS-1:0]                   af_enable,
    input  logic [7:0]                               af_period,
    input  logic                                     vsync,
`endif
    arcade_input_mapper_if.slave                     cfg,
    input  logic [1:0]                               socd_mode,
    output logic [NUM_PLAYERS*INPUTS_PER_PLAYER-1:0] btn_out,
    output logic                                     busy,
    output logic                                     ovf
);
    // state  | meaning
    // S_IDLE | no search running, waiting for a ps2_key toggle
    // S_SCAN | walking keymap entries, one per cycle, at idx
    localparam int              N        = NUM_PLAYERS * INPUTS_PER_PLAYER;
    localparam int              IW       = $clog2(N);
    localparam logic [IW:0]     N_LIM    = (IW+1)'(N);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t        state, state_nx;
    logic [8:0]    keymap [N];
    logic [N-1:0]  kb_state;
    logic          old_toggle;
    logic          ev;
    logic [9:0]    cur_ev, cur_ev_nx;
    logic [9:0]    pend_ev, pend_ev_nx;
    logic          pend_vld, pend_vld_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          ovf_nx;
    logic          hit;

    assign ev   = ps2_key[10] ^ old_toggle;
    assign busy = (state == S_SCAN);
    assign hit  = busy && (keymap[idx] != 9'd0) && (keymap[idx] == cur_ev[8:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            old_toggle <= 1'b0;
            cur_ev     <= '0;
            pend_ev    <= '0;
            pend_vld   <= 1'b0;
            idx        <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nx;
            old_toggle <= ps2_key[10];
            cur_ev     <= cur_ev_nx;
            pend_ev    <= pend_ev_nx;
            pend_vld   <= pend_vld_nx;
            idx        <= idx_nx;
            ovf        <= ovf_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cur_ev_nx   = cur_ev;
        pend_ev_nx  = pend_ev;
        pend_vld_nx = pend_vld;
        ovf_nx      = ovf;
        case (state)
            S_IDLE: begin
                if (ev) begin
                    state_nx  = S_SCAN;
                    idx_nx    = '0;
                    cur_ev_nx = ps2_key[9:0];
                end
            end
            S_SCAN: begin
                if (idx == LAST_IDX) begin
                    // pop the buffer; a same-cycle arrival refills it rather than dropping
                    if (pend_vld) begin
                        idx_nx      = '0;
                        cur_ev_nx   = pend_ev;
                        pend_vld_nx = ev;
                        pend_ev_nx  = ps2_key[9:0];
                    end else if (ev) begin
                        idx_nx    = '0;
                        cur_ev_nx = ps2_key[9:0];
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    idx_nx = idx + 1'b1;
                    if (ev) begin
                        if (!pend_vld) begin
                            pend_vld_nx = 1'b1;
                            pend_ev_nx  = ps2_key[9:0];
                        end else begin
                            ovf_nx = 1'b1;
                        end
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) keymap[i] <= 9'd0;
            kb_state <= '0;
        end else begin
            if (cfg.cfg_wr && ({1'b0, cfg.cfg_idx} < N_LIM))
                keymap[cfg.cfg_idx] <= cfg.cfg_code;
            if (hit)
                kb_state[idx] <= cur_ev[9];
        end
    end

    logic [N-1:0] raw;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic       vsync_q;
    logic [7:0] af_cnt;
    logic       af_phase;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q  <= 1'b0;
            af_cnt   <= 8'd0;
            af_phase <= 1'b1;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q) begin
                if (af_period == 8'd0) begin
                    af_cnt   <= 8'd0;
                    af_phase <= 1'b1;
                end else if ((af_cnt + 8'd1) >= af_period) begin
                    af_cnt   <= 8'd0;
                    af_phase <= ~af_phase;
                end else begin
                    af_cnt <= af_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        raw = kb_state | joy_in;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (af_enable[p] && !af_phase)
                raw[p*INPUTS_PER_PLAYER+4] = 1'b0;
        end
    end
`else
    assign raw = kb_state | joy_in;
`endif

    logic [N-1:0]           raw_q;
    logic [N-1:0]           clean;
    logic [NUM_PLAYERS-1:0] lr_left, lr_left_nx;
    logic [NUM_PLAYERS-1:0] ud_up, ud_up_nx;

    // Last-direction tracking runs in every mode so switching to mode 2 is seamless.
    always_comb begin
        clean      = raw;
        lr_left_nx = lr_left;
        ud_up_nx   = ud_up;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (raw[p*INPUTS_PER_PLAYER] && !raw_q[p*INPUTS_PER_PLAYER])
                lr_left_nx[p] = 1'b0;
            else if (raw[p*INPUTS_PER_PLAYER+1] && !raw_q[p*INPUTS_PER_PLAYER+1])
                lr_left_nx[p] = 1'b1;
            if (raw[p*INPUTS_PER_PLAYER+2] && !raw_q[p*INPUTS_PER_PLAYER+2])
                ud_up_nx[p] = 1'b0;
            else if (raw[p*INPUTS_PER_PLAYER+3] && !raw_q[p*INPUTS_PER_PLAYER+3])
                ud_up_nx[p] = 1'b1;
            case (socd_mode)
                2'd1: begin
                    if (raw[p*INPUTS_PER_PLAYER] && raw[p*INPUTS_PER_PLAYER+1]) begin
                        clean[p*INPUTS_PER_PLAYER]   = 1'b0;
                        clean[p*INPUTS_PER_PLAYER+1] = 1'b0;
                    end
                    if (raw[p*INPUTS_PER_PLAYER+2] && raw[p*INPUTS_PER_PLAYER+3]) begin
                        clean[p*INPUTS_PER_PLAYER+2] = 1'b0;
                        clean[p*INPUTS_PER_PLAYER+3] = 1'b0;
                    end
                end
                2'd2: begin
                    if (raw[p*INPUTS_PER_PLAYER] && raw[p*INPUTS_PER_PLAYER+1]) begin
                        clean[p*INPUTS_PER_PLAYER]   = ~lr_left_nx[p];
                        clean[p*INPUTS_PER_PLAYER+1] = lr_left_nx[p];
                    end
                    if (raw[p*INPUTS_PER_PLAYER+2] && raw[p*INPUTS_PER_PLAYER+3]) begin
                        clean[p*INPUTS_PER_PLAYER+2] = ~ud_up_nx[p];
                        clean[p*INPUTS_PER_PLAYER+3] = ud_up_nx[p];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            raw_q   <= '0;
            lr_left <= '0;
            ud_up   <= '0;
            btn_out <= '0;
        end else begin
            raw_q   <= raw;
            lr_left <= lr_left_nx;
            ud_up   <= ud_up_nx;
            btn_out <= clean;
        end
    end
endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised keyboard/joystick input mapper for arcade cores; generalises the hard-coded single-table PS/2 decode used in emu top levels.
- Runtime-loadable keymap: NUM_PLAYERS x INPUTS_PER_PLAYER entries, each holding one 9-bit PS/2 code.
- Sequential table search, one-deep event buffer, joystick merge, SOCD cleaning.
- Sits between hps_io (ps2_key, joystick_N, status) and the game core's control inputs.

Parameters:
- NUM_PLAYERS, 2, number of players (1..4).
- INPUTS_PER_PLAYER, 8, inputs per player (5..16). Bits 0..3 are right, left, down, up, in MiSTer joystick order. Bits 4.. are buttons.
- N (derived localparam), NUM_PLAYERS*INPUTS_PER_PLAYER, total entries.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  hps_io key word: [10] toggle, [9] pressed, [8:0] code.
- joy_in  in  N  joystick bits, packed player-major, OR'd into outputs.
- cfg_wr  in  1  keymap write strobe.
- cfg_idx  in  $clog2(N)  keymap entry index.
- cfg_code  in  9  scan code for the entry; 9'h000 = unmapped.
- socd_mode  in  2  0 = pass, 1 = opposites cancel, 2 = last-pressed wins.
- btn_out  out  N  merged, cleaned control state, registered.
- busy  out  1  search in progress.
- ovf  out  1  sticky: key event dropped.

Behaviour:
- Reset (async, reset_n=0) clears the following to 0: keymap entries, kb_state, btn_out, busy, ovf, the pending buffer, old_toggle, FSM state, and the SOCD last-direction regs. The FSM goes to IDLE.
- Event detect: old_toggle <= ps2_key[10]. A mismatch in any cycle is one event. Capture {pressed, code}.
- FSM IDLE: an event with no pending entry goes to SCAN, idx=0, busy=1 from the next cycle.
- FSM SCAN: one entry per cycle. If entry[idx] != 0 and entry[idx] == code, then kb_state[idx] <= pressed. All N entries are scanned, so one code may drive several inputs.
- End of SCAN: at idx=N-1, go to IDLE if no event is pending. If one is pending, pop it and restart SCAN at idx 0 with busy held at 1.
- Event timing: an event detected in cycle 0 starts its scan in cycle 1. kb_state[i] updates at the end of cycle 1+i. btn_out reflects it one cycle later.
- Pending buffer: holds one event. An event arriving during SCAN fills it. An event arriving while SCAN is active and the buffer is full is dropped and sets ovf=1. ovf clears only on reset.
- An event arriving in the same cycle the buffer pops is accepted into the buffer, not dropped.
- Config writes: cfg_wr is accepted every cycle, busy or not, and writes entry[cfg_idx] <= cfg_code. A scan reads the current entry value.
- Writing 0 to an entry does not clear its kb_state bit.
- cfg_idx >= N: write ignored.
- Merge: raw = kb_state | joy_in (plus autofire gating, see below). btn_out <= SOCD(raw) every cycle, i.e. one-cycle latency from joy_in.
- SOCD, per player, for the pairs left/right and up/down:
  - mode 0: unchanged.
  - mode 1: both set gives both 0.
  - mode 2: both set gives the direction whose rising edge in raw came latest. Simultaneous rise favours right/down.
  - mode 3: treated as 0.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- When defined, adds ports af_enable (in, NUM_PLAYERS) and af_period (in, 8; half-period in frames), plus vsync (in, 1; frame tick, rising edge counted).
- One 8-bit counter and phase bit are shared by all players. The counter counts vsync rising edges; when it reaches af_period it resets to 0 and the phase bit toggles. af_period=0 gives phase held 1.
- For a player with af_enable set, input bit 4 of raw is ANDed with the phase bit. The phase bit resets to 1.
- When not defined: no extra ports, bit 4 passes unmodified, zero extra logic.

Test Plan:
- Reset then scan: load entry 5 = 9'h029, then toggle ps2_key with pressed=1, code 029 at cycle 0 -> busy=1 over cycles 1..16, kb_state[5] set end of cycle 6, btn_out[5]=1 at cycle 7; release event -> btn_out[5]=0.
- Multi-map: entries 4 and 12 = 9'h014, press ctrl -> btn_out[4] and btn_out[12] both 1; entry 0 = 0 never matches code 000.
- Buffer/overflow: three toggles on consecutive cycles -> first scanned, second buffered then scanned back-to-back (busy continuous for 32 cycles), third dropped, ovf=1 until reset_n pulse.
- SOCD: joy_in bits 0 and 1 high: mode 0 -> both 1; mode 1 -> both 0; mode 2 with left rising after right -> left=1, right=0; mode 3 behaves as 0.
- Async reset mid-scan: assert reset_n=0 at idx 7 -> btn_out, busy, ovf and all entries are 0 immediately, before the next clk_sys edge.
- With ARCADE_INPUT_AUTOFIRE_EN, af_period=2, af_enable[0]=1, bit 4 held -> btn_out[4] pattern 1,1,0,0,1,1 per vsync pair; player 1 bit 4 (btn_out[12]) unaffected.
